// File: rtl/cordic_arb_pkg.sv
// Shared constants and FSM encoding for the CORDIC request arbiter.
package cordic_arb_pkg;

    localparam int ANGLE_W = 9;
    localparam int NREQ    = 4;

    localparam logic [ANGLE_W-1:0] ANGLE_LIMIT = 9'd360;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_START,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Four-way winner selection: first set request found searching upward from ptr.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] id
);

    logic [3:0] w_rot;

    always_comb begin
        // Rotate so that requester ptr lands on bit 0, then pick lowest set bit.
        w_rot = 4'({req, req} >> ptr);
        valid = |req;
        id    = ptr;
        if (w_rot[0])      id = ptr;
        else if (w_rot[1]) id = ptr + 2'd1;
        else if (w_rot[2]) id = ptr + 2'd2;
        else if (w_rot[3]) id = ptr + 2'd3;
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Arbitrates four requesters onto one external CORDIC sin/cos engine.
// Define CORDIC_ARB_ROUND_ROBIN_EN for round-robin selection; default is fixed priority.
module cordic_arbiter #(
    parameter int NREQ    = cordic_arb_pkg::NREQ,
    parameter int ANGLE_W = cordic_arb_pkg::ANGLE_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*ANGLE_W-1:0]   req_angle,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           rsp_valid,
    output logic signed [ANGLE_W-1:0] rsp_sin,
    output logic signed [ANGLE_W-1:0] rsp_cos,
    output logic                      cordic_start,
    output logic [ANGLE_W-1:0]        cordic_angle,
    input  logic signed [ANGLE_W-1:0] cordic_sin,
    input  logic signed [ANGLE_W-1:0] cordic_cos,
    input  logic                      cordic_done,
    output logic                      busy
);
    import cordic_arb_pkg::*;

    state_t                    r_state;
    state_t                    w_next;
    logic [1:0]                r_id;
    logic [ANGLE_W-1:0]        r_angle;
    logic signed [ANGLE_W-1:0] r_sin;
    logic signed [ANGLE_W-1:0] r_cos;

    logic                      w_valid;
    logic [1:0]                w_id;
    logic [1:0]                w_ptr;
    logic [ANGLE_W-1:0]        w_angles [NREQ];
    logic [ANGLE_W-1:0]        w_sel_angle;
    logic [ANGLE_W-1:0]        w_wrap_angle;

    for (genvar k = 0; k < NREQ; k++) begin : g_ang
        assign w_angles[k] = req_angle[k*ANGLE_W +: ANGLE_W];
    end

    assign w_sel_angle  = w_angles[w_id];
    assign w_wrap_angle = (w_sel_angle >= ANGLE_W'(ANGLE_LIMIT))
                        ? w_sel_angle - ANGLE_W'(ANGLE_LIMIT) : w_sel_angle;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (w_ptr),
        .valid (w_valid),
        .id    (w_id)
    );

`ifdef CORDIC_ARB_ROUND_ROBIN_EN
    logic [1:0] r_ptr;

    // Pointer advances past the requester just served, only on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  r_ptr <= 2'd0;
        else if (r_state == ST_RESP) r_ptr <= r_id + 2'd1;
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = 2'd0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        gnt          = '0;
        rsp_valid    = '0;
        cordic_start = 1'b0;
        busy         = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE:  if (w_valid) w_next = ST_GRANT;
            ST_GRANT: begin
                gnt    = NREQ'(1) << r_id;
                w_next = ST_START;
            end
            ST_START: begin
                cordic_start = 1'b1;
                w_next       = ST_WAIT;
            end
            ST_WAIT:  if (cordic_done) w_next = ST_RESP;
            ST_RESP: begin
                rsp_valid = NREQ'(1) << r_id;
                w_next    = ST_IDLE;
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    // Request and angle are captured once in IDLE; later req changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_id    <= 2'd0;
            r_angle <= '0;
            r_sin   <= '0;
            r_cos   <= '0;
        end else begin
            if (r_state == ST_IDLE && w_valid) begin
                r_id    <= w_id;
                r_angle <= w_wrap_angle;
            end
            if (r_state == ST_WAIT && cordic_done) begin
                r_sin <= cordic_sin;
                r_cos <= cordic_cos;
            end
        end
    end

    assign cordic_angle = r_angle;
    assign rsp_sin      = r_sin;
    assign rsp_cos      = r_cos;

endmodule
